// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the imem (slave).
// One request is outstanding at a time; the response may arrive any number of cycles (>= 1) later.
interface fetch_stage_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Purpose: pipeline fetch stage feeding the IF/ID register; FETCH_MISALIGN_EN adds misalign_d.
// Latency: instruction reaches IF/ID on the edge its imem_valid is seen (or when decode unstalls).
// Backpressure: stall_d parks one response in a local buffer; no new request issues until it drains.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(32'h0000_0000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  fetch_stage_if.master            imem,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                     misalign_d
`endif
);

  localparam logic [DATA_WIDTH-1:0]    NOP     = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0]    buf_q, buf_d;

  logic [DATA_WIDTH-1:0]    ifid_instr_q, ifid_instr_d;
  logic [ADDRESS_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDRESS_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                     ifid_vld_q, ifid_vld_d;

  logic                     issue;
  logic                     take_rsp;
  logic                     take_buf;
  logic                     capture;
  logic                     deliver;
  logic [DATA_WIDTH-1:0]    deliver_dat;

  assign pc_plus4_f = pc_f_q + PC_STEP;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect in DROP still retires the stale response if it lands in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (!pc_src_e && !stall_f) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_valid) begin
          state_d = (!pc_src_e && stall_d) ? ST_HOLD : ST_REQ;
        end else if (pc_src_e) begin
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (pc_src_e || !stall_d) state_d = ST_REQ;
      end
      ST_DROP: begin
        if (imem.imem_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    take_rsp = 1'b0;
    take_buf = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_REQ:  issue = !stall_f && !pc_src_e;
      ST_WAIT: begin
        capture  = imem.imem_valid && !pc_src_e && stall_d;
        take_rsp = imem.imem_valid && !pc_src_e && !stall_d;
      end
      ST_HOLD: take_buf = !pc_src_e && !stall_d;
      default: ;
    endcase
  end

  assign deliver     = take_rsp || take_buf;
  assign deliver_dat = take_buf ? buf_q : imem.imem_rdata;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_f_q;

  // ------------------------------------------------------ PC and buffer
  // A flushed delivery still consumes its slot, so the PC steps past it.
  always_comb begin
    pc_f_d = pc_f_q;
    if (pc_src_e)     pc_f_d = pc_target_e;
    else if (deliver) pc_f_d = pc_plus4_f;
  end

  assign buf_d = capture ? imem.imem_rdata : buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      buf_q  <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      buf_q  <= buf_d;
    end
  end

  // ------------------------------------------------------------- IF/ID
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    if (flush_d || (!stall_d && !deliver)) begin
      ifid_instr_d = NOP;
      ifid_vld_d   = 1'b0;
    end else if (!stall_d) begin
      ifid_instr_d = deliver_dat;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_plus4_f;
      ifid_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_vld_q   <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_vld_q;

`ifdef FETCH_MISALIGN_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (flush_d || (!stall_d && !deliver)) mis_d = 1'b0;
    else if (!stall_d)                     mis_d = (pc_f_q[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign_d = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with an imem responder and a transaction-level reference model.
module tb_fetch_stage;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_MISALIGN_EN
  logic        misalign_d;
`endif

  fetch_stage_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_stage #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (bus),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_d  (misalign_d)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending request, whether its answer is already void, and a parked instruction.
  logic [31:0] m_pc, m_hdat, m_instr, m_pcd, m_pcp4;
  bit          m_busy, m_stale, m_held, m_vld, m_mis;

  // imem responder
  bit          mem_pend, mem_drv;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          lat_min = 1, lat_max = 1, spur_pct = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_hdat = '0;
    m_busy = 0; m_stale = 0; m_held = 0;
    m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_vld = 0; m_mis = 0;
  endtask

  function automatic bit exp_req();
    return !m_busy && !m_held && !stall_f && !pc_src_e;
  endfunction

  task automatic model_step();
    bit          deliver;
    logic [31:0] ddat;
    deliver = 0;
    ddat    = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_held) begin
      if (pc_src_e) m_held = 0;
      else if (!stall_d) begin deliver = 1; ddat = m_hdat; m_held = 0; end
    end else if (m_busy) begin
      if (m_stale || pc_src_e) begin
        if (bus.imem_valid) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end else if (bus.imem_valid) begin
        m_busy = 0;
        if (stall_d) begin m_held = 1; m_hdat = bus.imem_rdata; end
        else begin deliver = 1; ddat = bus.imem_rdata; end
      end
    end else if (!stall_f && !pc_src_e) begin
      m_busy = 1;
    end

    if (flush_d) begin
      m_instr = NOP; m_vld = 0; m_mis = 0;
    end else if (!stall_d) begin
      if (deliver) begin
        m_instr = ddat; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_vld = 1;
        m_mis = (m_pc[1:0] != 2'b00);
      end else begin
        m_instr = NOP; m_vld = 0; m_mis = 0;
      end
    end

    if (pc_src_e)     m_pc = pc_target_e;
    else if (deliver) m_pc = m_pc + 32'd4;
  endtask

  task automatic mem_drive();
    mem_drv = 0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        mem_drv = 1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_fn(mem_addr);
      end else begin
        mem_wait--;
      end
    end else if (!m_held && ($urandom_range(99) < spur_pct)) begin
      bus.imem_valid = 1'b1;
    end
  endtask

  task automatic mem_edge();
    if (mem_drv) mem_pend = 0;
    if (rst_n && bus.imem_req) begin
      mem_pend = 1;
      mem_addr = bus.imem_addr;
      mem_wait = int'($urandom_range(lat_max - 1, lat_min - 1));
    end
  endtask

  task automatic check_all();
    chk("imem_req",   {31'b0, bus.imem_req}, {31'b0, exp_req()});
    chk("imem_addr",  bus.imem_addr, m_pc);
    chk("instr_d",    instr_d, m_instr);
    chk("pc_d",       pc_d, m_pcd);
    chk("pc_plus4_d", pc_plus4_d, m_pcp4);
    chk("valid_d",    {31'b0, valid_d}, {31'b0, m_vld});
`ifdef FETCH_MISALIGN_EN
    chk("misalign_d", {31'b0, misalign_d}, {31'b0, m_mis});
`endif
  endtask

  // Inputs are set by the caller just after an edge; compare, then cross the next edge.
  task automatic tick();
    mem_drive();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    mem_edge();
    #1;
  endtask

  logic [31:0] tgt;

  initial begin
    mem_pend = 0; mem_drv = 0; mem_addr = '0; mem_wait = 0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;
    #1;
    rst_n = 1'b0;
    model_reset();
    tick();
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_valid", {31'b0, valid_d}, 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_pcp4",  pc_plus4_d, 32'h0);

    // Latency-1 streaming after reset
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      chk("seq_pc_d",  pc_d, 32'(4 * k));
      chk("seq_pcp4",  pc_plus4_d, 32'(4 * k + 4));
      chk("seq_valid", {31'b0, valid_d}, 32'h1);
      chk("seq_instr", instr_d, mem_fn(32'(4 * k)));
      chk("seq_addr",  bus.imem_addr, 32'(4 * k + 4));
    end

    // Response lands while decode is stalled for three cycles
    tick();
    stall_d = 1'b1;
    tick();
    tick();
    chk("hold_no_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("hold_valid", {31'b0, valid_d}, 32'h0);
    chk("hold_pc_d",  pc_d, 32'h8);
    stall_d = 1'b0;
    tick();
    chk("unhold_pc_d",  pc_d, 32'hC);
    chk("unhold_valid", {31'b0, valid_d}, 32'h1);
    chk("unhold_instr", instr_d, mem_fn(32'hC));
    chk("unhold_addr",  bus.imem_addr, 32'h10);

    // Redirect while waiting; the stale answer arrives two cycles later
    lat_min = 3; lat_max = 3;
    tick();
    pc_src_e = 1'b1; pc_target_e = 32'h100;
    tick();
    pc_src_e = 1'b0;
    tick();
    tick();
    chk("drop_addr",  bus.imem_addr, 32'h100);
    chk("drop_valid", {31'b0, valid_d}, 32'h0);
    lat_min = 1; lat_max = 1;
    tick();
    tick();
    chk("redir_pc_d",  pc_d, 32'h100);
    chk("redir_instr", instr_d, mem_fn(32'h100));

    // Flush on delivery, then flush together with a redirect
    tick();
    flush_d = 1'b1;
    tick();
    chk("flush_instr", instr_d, 32'h0000_0013);
    chk("flush_valid", {31'b0, valid_d}, 32'h0);
    chk("flush_addr",  bus.imem_addr, 32'h108);
    flush_d = 1'b0;
    tick();
    flush_d = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h200;
    tick();
    chk("flushbr_addr",  bus.imem_addr, 32'h200);
    chk("flushbr_valid", {31'b0, valid_d}, 32'h0);
    flush_d = 1'b0; pc_src_e = 1'b0;

    // PC wrap at the top of the address space
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 1'b0;
    tick();
    tick();
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pcp4", pc_plus4_d, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_EN
    pc_src_e = 1'b1; pc_target_e = 32'h102;
    tick();
    pc_src_e = 1'b0;
    tick();
    tick();
    chk("mis_pc_d", pc_d, 32'h102);
    chk("mis_flag", {31'b0, misalign_d}, 32'h1);
`endif

    // Randomized traffic with variable latency, spurious valids and mid-run resets
    lat_min = 1; lat_max = 4; spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      stall_f  = ($urandom_range(99) < 25);
      stall_d  = ($urandom_range(99) < 25);
      flush_d  = ($urandom_range(99) < 8);
      pc_src_e = ($urandom_range(99) < 8);
      case ($urandom_range(3))
        0: tgt = $urandom & 32'hFFFF_FFFC;
        1: tgt = 32'($urandom_range(255)) << 2;
        2: tgt = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
        default: tgt = $urandom;
      endcase
      pc_target_e = tgt;
      if (i == 1500 || i == 2500) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port stall_f  input  1  hazard unit; inhibits issue of a new fetch request.
REQ-007 SHALL have port stall_d  input  1  hazard unit; decode cannot accept, so the IF/ID register holds.
REQ-008 SHALL have port flush_d  input  1  hazard unit; the IF/ID register loads a bubble.
REQ-009 SHALL have port pc_src_e  input  1  redirect from execute (taken branch/jump).
REQ-010 SHALL have port pc_target_e  input  ADDRESS_WIDTH  redirect address.
REQ-011 SHALL have port imem_req  output  1  one-cycle fetch request strobe.
REQ-012 SHALL have port imem_addr  output  ADDRESS_WIDTH  fetch address, equal to pc_f.
REQ-013 SHALL have port imem_rdata  input  DATA_WIDTH  returned instruction.
REQ-014 SHALL have port imem_valid  input  1  imem_rdata valid; latency is at least 1 cycle after imem_req, variable.
REQ-015 SHALL have ports instr_d, pc_d, pc_plus4_d  output  DATA_WIDTH/ADDRESS_WIDTH  IF/ID register contents feeding decode.
REQ-016 SHALL have port valid_d  output  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD, DROP, with one request outstanding at most.
REQ-018 In REQ, SHALL drive imem_req = !stall_f && !pc_src_e; an issued request moves the FSM to WAIT.
REQ-019 In WAIT, on imem_valid with stall_d=0, SHALL load instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4 and valid_d=1, set pc_f<=pc_f+4, and go to REQ.
REQ-020 In WAIT, on imem_valid with stall_d=1, SHALL capture rdata into a 1-entry buffer and go to HOLD; the IF/ID register holds.
REQ-021 In HOLD, SHALL transfer the buffer to IF/ID, set pc_f<=pc_f+4 and go to REQ in the first cycle that stall_d=0.
REQ-022 If stall_d=0 and no instruction is delivered in a cycle, SHALL load a bubble: instr_d=32'h0000_0013, valid_d=0, and pc_d/pc_plus4_d unchanged.
REQ-023 If stall_d=1 and flush_d=0, the IF/ID register SHALL hold all values.
REQ-024 flush_d SHALL load a bubble regardless of stall_d, and SHALL have priority over delivery; any delivered data is discarded.
REQ-025 pc_src_e SHALL set pc_f<=pc_target_e; in REQ it stays in REQ; in WAIT without imem_valid it goes to DROP; in WAIT with imem_valid, or in HOLD, it discards the data and goes to REQ.
REQ-026 pc_src_e SHALL take priority over stall_f and stall_d for pc_f update and FSM transitions.
REQ-027 In DROP, on imem_valid, SHALL discard the data and go to REQ; a further pc_src_e in DROP updates pc_f and stays in DROP.
REQ-028 pc_f+4 SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-029 imem_valid in REQ SHALL be ignored.

Reset
REQ-030 On rst_n=0, SHALL asynchronously set pc_f=RESET_PC, state=REQ, buffer=0, instr_d=32'h0000_0013, pc_d=0, pc_plus4_d=0 and valid_d=0.
REQ-031 The first request SHALL issue in the first cycle after rst_n deasserts; reset mid-fetch abandons the outstanding request, and a late imem_valid arriving in REQ is ignored per REQ-029.

Configuration
REQ-032 With FETCH_MISALIGN_EN defined, SHALL add output misalign_d (1 bit) asserted with valid_d when pc_d[1:0]!=0, with reset value 0; a misaligned pc_target_e is still fetched.
REQ-033 Without FETCH_MISALIGN_EN, the misalign_d port and its logic SHALL be absent.

Verification
REQ-034 Reset, with imem latency 1 and no stalls -> imem_addr is 0,4,8 on alternate cycles; valid_d pulses with pc_d=0,4,8 and pc_plus4_d=4,8,C.
REQ-035 Response arrives with stall_d=1 for 3 cycles -> HOLD; IF/ID unchanged for 3 cycles; the instruction appears in the cycle after stall_d falls; no imem_req is issued during HOLD.
REQ-036 pc_src_e=1 with pc_target_e=0x100 while in WAIT, and the response arrives 2 cycles later -> the response is dropped; the next imem_addr=0x100; valid_d never shows the stale instruction.
REQ-037 flush_d=1 in the same cycle as imem_valid -> instr_d=0x00000013, valid_d=0, and pc_f advances only if no redirect is present.
REQ-038 pc_f=0xFFFFFFFC, fetch delivered -> pc_plus4_d=0, and the next imem_addr=0.
REQ-039 With FETCH_MISALIGN_EN defined, redirect to 0x102 -> misalign_d=1 alongside valid_d for pc_d=0x102.
